// File: rtl/lightgun_hv_latch.sv
// Light-gun H/V counter latch: tracks beam position from video timing strobes and
// freezes it on the first filtered sensor rise per frame, raising an external interrupt.
module lightgun_hv_latch #(
  parameter int FILTER = 2,
  parameter int VBITS  = 9
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CE_PIX,
  input  logic        HDE,
  input  logic        VDE,
  input  logic        H40,
  input  logic        SENSOR,
  input  logic        LATCH_EN,
  input  logic        IE2,
  input  logic        HV_RD,
  input  logic        INT_ACK,
  output logic [15:0] HV_OUT,
  output logic        HL_VALID,
  output logic        EXT_INT
);

  typedef enum logic [1:0] {DISARMED, ARMED, LATCHED} state_e;

  localparam logic [3:0] FMAX = 4'(FILTER);
  localparam logic [3:0] FPRE = 4'(FILTER - 1);

  state_e             state_q, state_d;
  logic [8:0]         hcnt_q;
  logic [VBITS-1:0]   vcnt_q;
  logic               hde_q, vde_q;
  logic               s1_q, s2_q;
  logic [3:0]         fcnt_q;
  logic [15:0]        hv_q;
  logic               ext_q, ext_d;
  logic               hde_fall, vde_fall, frame_start, qual_edge, capture;
  logic [7:0]         live_h;
  logic [15:0]        live_hv;

  assign hde_fall    = CE_PIX && hde_q && !HDE;
  assign vde_fall    = CE_PIX && vde_q && !VDE;
  assign frame_start = CE_PIX && !vde_q && VDE;
  // Edge fires in the sample that moves the filter count onto FILTER.
  assign qual_edge   = CE_PIX && s2_q && (fcnt_q == FPRE);

  always_comb begin
    live_h = hcnt_q[8:1];
    if (H40 && hcnt_q >= 9'd320)       live_h = 8'hA0;
    else if (!H40 && hcnt_q >= 9'd256) live_h = 8'h80;
  end

  assign live_hv  = {vcnt_q[7:0], live_h};
  assign HV_OUT   = HL_VALID ? hv_q : live_hv;
  assign HL_VALID = (state_q == LATCHED);
  assign EXT_INT  = ext_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hde_q  <= 1'b0;
      vde_q  <= 1'b0;
      fcnt_q <= '0;
    end else if (CE_PIX) begin
      hde_q <= HDE;
      vde_q <= VDE;
      if (!HDE)                hcnt_q <= '0;
      else if (hcnt_q != '1)   hcnt_q <= hcnt_q + 9'd1;
      if (vde_fall)                              vcnt_q <= '0;
      else if (hde_fall && VDE && vcnt_q != '1)  vcnt_q <= vcnt_q + 1'b1;
      if (!s2_q)               fcnt_q <= '0;
      else if (fcnt_q != FMAX) fcnt_q <= fcnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= DISARMED;
      hv_q    <= '0;
      ext_q   <= 1'b0;
    end else begin
      s1_q    <= SENSOR;
      s2_q    <= s1_q;
      state_q <= state_d;
      ext_q   <= ext_d;
      if (capture) hv_q <= live_hv;
    end
  end

  // Frame start beats a coincident edge: the edge is dropped and we stay armed.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (!LATCH_EN) begin
      state_d = DISARMED;
    end else begin
      unique case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (qual_edge && !frame_start) begin
            capture = 1'b1;
            state_d = LATCHED;
          end
        end
        LATCHED:  if (frame_start) state_d = ARMED;
        default:  state_d = DISARMED;
      endcase
    end
  end

  always_comb begin
    ext_d = ext_q;
    if (capture && IE2)          ext_d = 1'b1;
    else if (INT_ACK || HV_RD)   ext_d = 1'b0;
  end

endmodule

// File: tb/tb_lightgun_hv_latch.sv
// Directed bench for lightgun_hv_latch; CE_PIX held high so every CLK is one pixel.
module tb_lightgun_hv_latch;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CE_PIX = 1'b1;
  logic        HDE = 1'b0, VDE = 1'b0, H40 = 1'b0, SENSOR = 1'b0;
  logic        LATCH_EN = 1'b0, IE2 = 1'b0, HV_RD = 1'b0, INT_ACK = 1'b0;
  logic [15:0] HV_OUT;
  logic        HL_VALID, EXT_INT;
  int          checks = 0;
  int          failures = 0;

  lightgun_hv_latch #(.FILTER(2), .VBITS(9)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HDE(HDE), .VDE(VDE),
    .H40(H40), .SENSOR(SENSOR), .LATCH_EN(LATCH_EN), .IE2(IE2),
    .HV_RD(HV_RD), .INT_ACK(INT_ACK), .HV_OUT(HV_OUT),
    .HL_VALID(HL_VALID), .EXT_INT(EXT_INT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic new_frame();
    VDE = 1'b0; HDE = 1'b0; clk(2);
    VDE = 1'b1; clk(1);
  endtask

  task automatic lines(input int n);
    repeat (n) begin
      HDE = 1'b1; clk(1);
      HDE = 1'b0; clk(1);
    end
  endtask

  task automatic run_px(input int n);
    HDE = 1'b1; clk(n);
  endtask

  initial begin
    #2;
    check("rst_hv", HV_OUT, 16'h0000);
    check("rst_valid", {15'd0, HL_VALID}, 16'd0);
    check("rst_int", {15'd0, EXT_INT}, 16'd0);
    #10 RESET_N = 1'b1;
    LATCH_EN = 1'b1; IE2 = 1'b1; H40 = 1'b0;

    // 1: capture at line 100, hcnt 64 in H32
    new_frame(); lines(100); run_px(61);
    SENSOR = 1'b1; clk(3);
    check("t1_pre_live", HV_OUT, 16'h6420);
    check("t1_pre_valid", {15'd0, HL_VALID}, 16'd0);
    clk(1); SENSOR = 1'b0; HDE = 1'b0; clk(1);
    check("t1_hv", HV_OUT, 16'h6420);
    check("t1_valid", {15'd0, HL_VALID}, 16'd1);
    check("t1_int", {15'd0, EXT_INT}, 16'd1);
    INT_ACK = 1'b1; clk(1); INT_ACK = 1'b0;
    check("t1_ack_int", {15'd0, EXT_INT}, 16'd0);
    check("t1_ack_hv", HV_OUT, 16'h6420);

    // 2: second pulse same frame ignored, next frame re-arms
    lines(49); run_px(20);
    SENSOR = 1'b1; clk(4); SENSOR = 1'b0; HDE = 1'b0; clk(2);
    check("t2_hold_hv", HV_OUT, 16'h6420);
    check("t2_hold_int", {15'd0, EXT_INT}, 16'd0);
    new_frame();
    check("t2_rearm_valid", {15'd0, HL_VALID}, 16'd0);
    check("t2_rearm_live", HV_OUT, 16'h0000);
    lines(40); run_px(197);
    SENSOR = 1'b1; clk(4); SENSOR = 1'b0; HDE = 1'b0; clk(1);
    check("t2_hv", HV_OUT, 16'h2864);
    check("t2_int", {15'd0, EXT_INT}, 16'd1);
    HV_RD = 1'b1; clk(1); HV_RD = 1'b0;
    check("t2_rd_int", {15'd0, EXT_INT}, 16'd0);
    check("t2_rd_hv", HV_OUT, 16'h2864);

    // 3: single-sample glitch is filtered out
    new_frame(); clk(2); lines(10); run_px(10);
    SENSOR = 1'b1; clk(1); SENSOR = 1'b0; clk(6);
    check("t3_valid", {15'd0, HL_VALID}, 16'd0);
    check("t3_int", {15'd0, EXT_INT}, 16'd0);
    check("t3_live", HV_OUT, 16'h0A08);

    // 4: IE2=0 capture, then LATCH_EN drop
    IE2 = 1'b0;
    SENSOR = 1'b1; clk(4); SENSOR = 1'b0; HDE = 1'b0; clk(1);
    check("t4_valid", {15'd0, HL_VALID}, 16'd1);
    check("t4_int", {15'd0, EXT_INT}, 16'd0);
    check("t4_hv", HV_OUT, 16'h0A0A);
    LATCH_EN = 1'b0; clk(1);
    check("t4_dis_valid", {15'd0, HL_VALID}, 16'd0);
    check("t4_dis_live", HV_OUT, 16'h0B00);
    LATCH_EN = 1'b1; IE2 = 1'b1;

    // 5: H40 clamp, then edge coincident with frame start is dropped
    H40 = 1'b1; clk(3);
    new_frame(); lines(5); run_px(327);
    SENSOR = 1'b1; clk(4); SENSOR = 1'b0; HDE = 1'b0; clk(1);
    check("t5_clamp", HV_OUT, 16'h05A0);
    INT_ACK = 1'b1; clk(1); INT_ACK = 1'b0;
    VDE = 1'b0; clk(4);
    SENSOR = 1'b1; clk(3);
    VDE = 1'b1; clk(1);
    check("t5_coinc_valid", {15'd0, HL_VALID}, 16'd0);
    check("t5_coinc_int", {15'd0, EXT_INT}, 16'd0);
    SENSOR = 1'b0; clk(3);
    SENSOR = 1'b1; clk(4); SENSOR = 1'b0; clk(1);
    check("t5_armed_valid", {15'd0, HL_VALID}, 16'd1);
    check("t5_armed_int", {15'd0, EXT_INT}, 16'd1);
    INT_ACK = 1'b1; clk(1); INT_ACK = 1'b0;

    // 6: set beats ack in capture cycle, then async reset mid-frame
    new_frame(); clk(2); lines(3); run_px(5);
    SENSOR = 1'b1; clk(3);
    INT_ACK = 1'b1; clk(1); INT_ACK = 1'b0; SENSOR = 1'b0;
    check("t6_setwins", {15'd0, EXT_INT}, 16'd1);
    check("t6_hv", HV_OUT, 16'h0304);
    #2 RESET_N = 1'b0;
    #1;
    check("t6_rst_hv", HV_OUT, 16'h0000);
    check("t6_rst_valid", {15'd0, HL_VALID}, 16'd0);
    check("t6_rst_int", {15'd0, EXT_INT}, 16'd0);
    #2 RESET_N = 1'b1;
    clk(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
